// File: rtl/sky130_fd_io__gpiovrefv2_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sky130_fd_io__gpiovrefv2_ctrl_if
// Description : Configuration request/completion bundle for the vrefgen
//               control sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface sky130_fd_io__gpiovrefv2_ctrl_if;
    logic       cfg_valid;
    logic [4:0] cfg_sel;
    logic       cfg_en;
    logic       cfg_ready;
    logic       cfg_done;
    logic       cfg_err;

    modport master (
        output cfg_valid, cfg_sel, cfg_en,
        input  cfg_ready, cfg_done, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_sel, cfg_en,
        output cfg_ready, cfg_done, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/sky130_fd_io__gpiovrefv2_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sky130_fd_io__gpiovrefv2_ctrl
// Description : Setup / latch-open / hold sequencer for the GPIO_OVTV2 vrefgen
//               latched controls. Optional startup wait is compiled in when
//               SKY130_FD_IO__GPIOVREFV2_CTRL_STARTUP_WAIT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module sky130_fd_io__gpiovrefv2_ctrl #(
    parameter int unsigned SETUP_CYCLES   = 4,
    parameter int unsigned OPEN_CYCLES    = 4,
    parameter int unsigned HOLD_CYCLES    = 4,
    parameter int unsigned STARTUP_CYCLES = 2400,
    parameter int unsigned MAX_SEL        = 31
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable_h,
    sky130_fd_io__gpiovrefv2_ctrl_if.slave       cfg,
    output logic [4:0]                           ref_sel,
    output logic                                 vrefgen_en,
    output logic                                 hld_h_n,
    output logic                                 vref_ready,
    output logic                                 busy
);

    localparam int unsigned c_MAX_SO  = (SETUP_CYCLES > OPEN_CYCLES) ? SETUP_CYCLES : OPEN_CYCLES;
    localparam int unsigned c_MAX_SOH = (c_MAX_SO > HOLD_CYCLES) ? c_MAX_SO : HOLD_CYCLES;
`ifdef SKY130_FD_IO__GPIOVREFV2_CTRL_STARTUP_WAIT_EN
    localparam int unsigned c_CNT_MAX = (c_MAX_SOH > STARTUP_CYCLES) ? c_MAX_SOH : STARTUP_CYCLES;
`else
    localparam int unsigned c_CNT_MAX = c_MAX_SOH;
`endif
    localparam int c_CNT_W = $clog2(c_CNT_MAX) + 1;

    localparam logic [c_CNT_W-1:0] c_SETUP_LD = c_CNT_W'(SETUP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_OPEN_LD  = c_CNT_W'(OPEN_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LD  = c_CNT_W'(HOLD_CYCLES - 1);
`ifdef SKY130_FD_IO__GPIOVREFV2_CTRL_STARTUP_WAIT_EN
    localparam logic [c_CNT_W-1:0] c_SETTLE_LD = c_CNT_W'(STARTUP_CYCLES - 1);
`endif

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_SETUP  = 3'd1;
    localparam logic [2:0] c_ST_OPEN   = 3'd2;
    localparam logic [2:0] c_ST_HOLD   = 3'd3;
`ifdef SKY130_FD_IO__GPIOVREFV2_CTRL_STARTUP_WAIT_EN
    localparam logic [2:0] c_ST_SETTLE = 3'd4;
`endif

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [4:0]         r_ref_sel;
    logic               r_vrefgen_en;
    logic               r_hld_h_n;
    logic               r_vref_ready;
    logic               r_cfg_done;
    logic               r_cfg_err;
    logic               r_rej_pend;

    logic w_cfg_ready;
    logic w_sel_bad;
    logic w_cnt_zero;

    // A pending reject keeps the port closed until its done/err pulse appears.
    assign w_cfg_ready = (r_state == c_ST_IDLE) && enable_h && !reset && !r_rej_pend;
    assign w_sel_bad   = 32'(cfg.cfg_sel) > MAX_SEL;
    assign w_cnt_zero  = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_ref_sel    <= 5'd0;
            r_vrefgen_en <= 1'b0;
            r_hld_h_n    <= 1'b0;
            r_vref_ready <= 1'b0;
            r_cfg_done   <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_rej_pend   <= 1'b0;
        end else begin
            r_cfg_done <= r_rej_pend;
            r_cfg_err  <= r_rej_pend;
            r_rej_pend <= 1'b0;

            if (!enable_h) begin
                // Shadow tracks the vrefgen latch, which is forced to zero.
                r_state      <= c_ST_IDLE;
                r_ref_sel    <= 5'd0;
                r_vrefgen_en <= 1'b0;
                r_hld_h_n    <= 1'b0;
                r_vref_ready <= 1'b0;
                if (r_state != c_ST_IDLE) begin
                    r_cfg_done <= 1'b1;
                    r_cfg_err  <= 1'b1;
                end
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (cfg.cfg_valid && w_cfg_ready) begin
                            if (w_sel_bad) begin
                                r_rej_pend <= 1'b1;
                            end else begin
                                r_ref_sel    <= cfg.cfg_sel;
                                r_vrefgen_en <= cfg.cfg_en;
                                r_vref_ready <= 1'b0;
                                r_cnt        <= c_SETUP_LD;
                                r_state      <= c_ST_SETUP;
                            end
                        end
                    end
                    c_ST_SETUP: begin
                        if (w_cnt_zero) begin
                            r_hld_h_n <= 1'b1;
                            r_cnt     <= c_OPEN_LD;
                            r_state   <= c_ST_OPEN;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    c_ST_OPEN: begin
                        if (w_cnt_zero) begin
                            r_hld_h_n <= 1'b0;
                            r_cnt     <= c_HOLD_LD;
                            r_state   <= c_ST_HOLD;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    c_ST_HOLD: begin
                        if (w_cnt_zero) begin
`ifdef SKY130_FD_IO__GPIOVREFV2_CTRL_STARTUP_WAIT_EN
                            if (r_vrefgen_en) begin
                                r_cnt   <= c_SETTLE_LD;
                                r_state <= c_ST_SETTLE;
                            end else begin
                                r_cfg_done <= 1'b1;
                                r_state    <= c_ST_IDLE;
                            end
`else
                            r_cfg_done   <= 1'b1;
                            r_vref_ready <= r_vrefgen_en;
                            r_state      <= c_ST_IDLE;
`endif
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
`ifdef SKY130_FD_IO__GPIOVREFV2_CTRL_STARTUP_WAIT_EN
                    c_ST_SETTLE: begin
                        if (w_cnt_zero) begin
                            r_cfg_done   <= 1'b1;
                            r_vref_ready <= 1'b1;
                            r_state      <= c_ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
`endif
                    default: begin
                        r_hld_h_n <= 1'b0;
                        r_state   <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign cfg.cfg_ready = w_cfg_ready;
    assign cfg.cfg_done  = r_cfg_done;
    assign cfg.cfg_err   = r_cfg_err;
    assign ref_sel       = r_ref_sel;
    assign vrefgen_en    = r_vrefgen_en;
    assign hld_h_n       = r_hld_h_n;
    assign vref_ready    = r_vref_ready;
    assign busy          = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sky130_fd_io__gpiovrefv2_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sky130_fd_io__gpiovrefv2_ctrl
// Description : Randomized bench for the vrefgen control sequencer against a
//               transaction-timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sky130_fd_io__gpiovrefv2_ctrl;

    localparam int c_S   = 4;
    localparam int c_O   = 4;
    localparam int c_H   = 4;
    localparam int c_T   = 2400;
    localparam int c_MAX = 23;
`ifdef SKY130_FD_IO__GPIOVREFV2_CTRL_STARTUP_WAIT_EN
    localparam bit c_WAIT = 1'b1;
`else
    localparam bit c_WAIT = 1'b0;
`endif
    localparam int c_CYCLES = 30000;

    logic       clk;
    logic       reset;
    logic       enable_h;
    logic [4:0] ref_sel;
    logic       vrefgen_en;
    logic       hld_h_n;
    logic       vref_ready;
    logic       busy;

    sky130_fd_io__gpiovrefv2_ctrl_if cfg_bus ();

    sky130_fd_io__gpiovrefv2_ctrl #(
        .SETUP_CYCLES   (c_S),
        .OPEN_CYCLES    (c_O),
        .HOLD_CYCLES    (c_H),
        .STARTUP_CYCLES (c_T),
        .MAX_SEL        (c_MAX)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .enable_h   (enable_h),
        .cfg        (cfg_bus.slave),
        .ref_sel    (ref_sel),
        .vrefgen_en (vrefgen_en),
        .hld_h_n    (hld_h_n),
        .vref_ready (vref_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: a request is a timeline starting at its accept edge.
    int         cyc = 0;
    int         m_t0 = 0;
    int         m_total = 0;
    bit         m_active = 0;
    bit         m_rej = 0;
    bit         m_acc = 0;
    logic [4:0] m_sel = 5'd0;
    bit         m_en = 0;
    bit         m_vref = 0;
    bit         m_done = 0;
    bit         m_err = 0;

    always @(posedge clk) begin
        bit rdy;
        cyc++;
        rdy    = !reset && enable_h && !m_active && !m_rej;
        m_acc  = 0;
        m_done = 0;
        m_err  = 0;
        if (reset) begin
            m_active = 0; m_rej = 0;
            m_sel = 5'd0; m_en = 0; m_vref = 0;
        end else begin
            if (m_rej) begin
                m_done = 1; m_err = 1; m_rej = 0;
            end
            if (!enable_h) begin
                if (m_active) begin
                    m_done = 1; m_err = 1; m_active = 0;
                end
                m_sel = 5'd0; m_en = 0; m_vref = 0;
            end else if (m_active) begin
                if (cyc - m_t0 == m_total) begin
                    m_active = 0; m_done = 1; m_vref = m_en;
                end
            end else if (cfg_bus.cfg_valid && rdy) begin
                m_acc = 1;
                if (int'(cfg_bus.cfg_sel) > c_MAX) begin
                    m_rej = 1;
                end else begin
                    m_active = 1;
                    m_t0     = cyc;
                    m_sel    = cfg_bus.cfg_sel;
                    m_en     = cfg_bus.cfg_en;
                    m_vref   = 0;
                    m_total  = c_S + c_O + c_H + ((c_WAIT && cfg_bus.cfg_en) ? c_T : 0);
                end
            end
        end
    end

    function automatic bit exp_hld();
        int d;
        d = cyc - m_t0;
        return m_active && (d >= c_S) && (d < c_S + c_O);
    endfunction

    logic [5:0] dir_sel [4];
    bit         dir_en  [4];
    int         dir_idx  = 0;
    bit         req_pend = 0;
    int         en_low   = 0;
    bit         did_drop = 0;
    bit         did_rst  = 0;

    initial begin
        dir_sel[0] = 6'd10; dir_en[0] = 1'b1;
        dir_sel[1] = 6'd10; dir_en[1] = 1'b0;
        dir_sel[2] = 6'd24; dir_en[2] = 1'b1;
        dir_sel[3] = 6'd3;  dir_en[3] = 1'b1;

        reset             = 1'b1;
        enable_h          = 1'b1;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_sel   = 5'd0;
        cfg_bus.cfg_en    = 1'b0;

        for (int c = 0; c < c_CYCLES; c++) begin
            @(negedge clk);
            check_val("ref_sel",    32'(ref_sel),         32'(m_sel));
            check_val("vrefgen_en", 32'(vrefgen_en),      32'(m_en));
            check_val("hld_h_n",    32'(hld_h_n),         32'(exp_hld()));
            check_val("vref_ready", 32'(vref_ready),      32'(m_vref));
            check_val("busy",       32'(busy),            32'(m_active));
            check_val("cfg_done",   32'(cfg_bus.cfg_done), 32'(m_done));
            check_val("cfg_err",    32'(cfg_bus.cfg_err),  32'(m_err));
            check_val("cfg_ready",  32'(cfg_bus.cfg_ready),
                      32'(!reset && enable_h && !m_active && !m_rej));

            if (c < 3) begin
                reset = 1'b1;
                continue;
            end
            reset = 1'b0;

            // Request source: directed list first, then random codes over the full 5-bit range.
            if (m_acc) req_pend = 0;
            if (!req_pend) begin
                if (dir_idx < 4) begin
                    req_pend        = 1;
                    cfg_bus.cfg_sel = dir_sel[dir_idx][4:0];
                    cfg_bus.cfg_en  = dir_en[dir_idx];
                    dir_idx++;
                end else if ($urandom_range(3, 0) == 0) begin
                    req_pend        = 1;
                    cfg_bus.cfg_sel = 5'($urandom_range(31, 0));
                    cfg_bus.cfg_en  = 1'($urandom_range(1, 0));
                end
            end
            cfg_bus.cfg_valid = req_pend;

            // Directed enable drop in OPEN, then a reset late in a sequence, then random disturbances.
            if (en_low > 0) begin
                en_low--;
                enable_h = (en_low == 0);
            end else if (dir_idx == 4 && !did_drop && m_active && !m_rej && (cyc - m_t0) == 5) begin
                did_drop = 1;
                en_low   = 3;
                enable_h = 1'b0;
            end else if (did_drop && !did_rst && m_active && (m_en || !c_WAIT) &&
                         (cyc - m_t0) == (c_WAIT ? c_S + c_O + c_H + 5 : 10)) begin
                did_rst = 1;
                reset   = 1'b1;
            end else if (did_rst && $urandom_range(1499, 0) == 0) begin
                en_low   = $urandom_range(4, 1);
                enable_h = 1'b0;
            end else if (did_rst && $urandom_range(4999, 0) == 0) begin
                reset = 1'b1;
            end
        end

        check_val("drop_taken", 32'(did_drop), 32'd1);
        check_val("rst_taken",  32'(did_rst),  32'd1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
